// File: rtl/dmem_load_store_unit.sv
// Load/store unit between the RV32I data path and a req/ack data memory.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing alignment.
module dmem_load_store_unit #(
  parameter int n           = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         wr_mem,
  input  logic [2:0]   func3,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] wdata,
  output logic [n-1:0] dataout_mem,
  output logic         lsu_busy,
  output logic         lsu_done,
  output logic         lsu_err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [3:0]   mem_be,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [n-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t       state_q;
  logic [7:0]   cnt_q;
  logic [2:0]   func3_q;
  logic [1:0]   off_q;
  logic [n-1:0] dataout_q, mem_addr_q, mem_wdata_q;
  logic [3:0]   mem_be_q;
  logic         done_q, err_q, mem_req_q, mem_we_q;

  logic         legal_d, misal_d;
  logic [1:0]   off_d;
  logic [3:0]   be_d;
  logic [n-1:0] wrep_d, ext_d;
  logic [7:0]   rbyte;
  logic [15:0]  rhalf;

  // Size/legality decode of the incoming request; off_d is the aligned lane offset.
  always_comb begin
    legal_d = 1'b0;
    misal_d = 1'b0;
    off_d   = addr[1:0];
    be_d    = 4'b0000;
    wrep_d  = wdata;
    case (func3)
      3'b000, 3'b100: begin
        legal_d = (func3 == 3'b000) || !wr_mem;
        be_d    = 4'b0001 << addr[1:0];
        wrep_d  = {4{wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        legal_d = (func3 == 3'b001) || !wr_mem;
        misal_d = addr[0];
        off_d   = {addr[1], 1'b0};
        be_d    = 4'b0011 << {addr[1], 1'b0};
        wrep_d  = {2{wdata[15:0]}};
      end
      3'b010: begin
        legal_d = 1'b1;
        misal_d = (addr[1:0] != 2'b00);
        off_d   = 2'b00;
        be_d    = 4'b1111;
      end
      default: ;
    endcase
  end

  // Lane extraction and extension of the returned word, using the latched offset.
  always_comb begin
    rbyte = mem_rdata[{off_q, 3'b000} +: 8];
    rhalf = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (func3_q)
      3'b000:  ext_d = {{(n-8){rbyte[7]}}, rbyte};
      3'b001:  ext_d = {{(n-16){rhalf[15]}}, rhalf};
      3'b100:  ext_d = {{(n-8){1'b0}}, rbyte};
      3'b101:  ext_d = {{(n-16){1'b0}}, rhalf};
      default: ext_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      func3_q     <= 3'b000;
      off_q       <= 2'b00;
      dataout_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (!legal_d) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= RESP;
`ifdef LSU_MISALIGN_TRAP_EN
            end else if (misal_d) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              if (!wr_mem) dataout_q <= '0;
              state_q <= RESP;
`endif
            end else begin
              mem_we_q    <= wr_mem;
              func3_q     <= func3;
              off_q       <= off_d;
              mem_addr_q  <= {addr[n-1:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wrep_d;
              mem_req_q   <= 1'b1;
              cnt_q       <= 8'd0;
              state_q     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // An ack arriving on the final count still completes normally.
          if (mem_ack) begin
            if (!mem_we_q) dataout_q <= ext_d;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            cnt_q     <= 8'd0;
            state_q   <= RESP;
          end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
            err_q     <= 1'b1;
            dataout_q <= '0;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            cnt_q     <= 8'd0;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // misal_d only steers behaviour when trapping is compiled in.
  logic unused_misal;
  assign unused_misal = misal_d;

  assign lsu_busy    = ((state_q == IDLE) && req_valid) || (state_q == ACCESS);
  assign lsu_done    = done_q;
  assign lsu_err     = err_q;
  assign dataout_mem = dataout_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_be      = mem_be_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
